// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the camera frame capture block
package cam_pkg;

  localparam int PIX_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  typedef enum logic {
    FMT_RGB444 = 1'b0,
    FMT_RGB565 = 1'b1
  } pix_fmt_t;

endpackage

// File: rtl/pixel_pack.sv
// rtl/pixel_pack.sv - combinational repack of two camera bytes into a 12-bit RGB pixel
module pixel_pack
  import cam_pkg::*;
(
  input  logic [7:0]       byte1_i,
  input  logic [7:0]       byte2_i,
  input  pix_fmt_t         fmt_i,
  output logic [PIX_W-1:0] rgb_o
);

  // RGB565 keeps the top 4 bits of each component; green straddles the byte boundary
  always_comb begin
    if (fmt_i == FMT_RGB565) begin
      rgb_o = {byte1_i[7:4], byte1_i[2:0], byte2_i[7], byte2_i[4:1]};
    end else begin
      rgb_o = {byte1_i[3:0], byte2_i[7:4], byte2_i[3:0]};
    end
  end

endmodule

// File: rtl/frame_capture.sv
// rtl/frame_capture.sv - camera frame capture with decimation and line checks
// FRAME_CAPTURE_STATS_EN adds saturating frame_cnt/err_cnt outputs
module frame_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 2,
  parameter int ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [7:0]        D,
  input  logic              vsync,
  input  logic              href,
  input  logic              fmt,
  input  logic              cont,
  input  logic              arm,
  output logic [PIX_W-1:0]  RGB,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              frame_done,
  output logic              line_err
`ifdef FRAME_CAPTURE_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
`endif
);

  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0] COL_END  = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [COL_W-1:0] COL_MASK = COL_W'(DECIM - 1);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'(DECIM - 1);

  cap_state_t        state_q, state_d;
  logic              vsync_q, href_q;
  logic              phase_q, phase_d;
  logic [7:0]        byte1_q, byte1_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  rgb_q, rgb_d, rgb_pack;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic vs_fall, href_fall, in_active, start_frame;
  logic pix_done, pix_taken, pix_keep, last_pix;

  pixel_pack u_pack (
    .byte1_i (byte1_q),
    .byte2_i (D),
    .fmt_i   (pix_fmt_t'(fmt)),
    .rgb_o   (rgb_pack)
  );

  assign vs_fall   = vsync_q && !vsync;
  assign href_fall = href_q && !href;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cont || arm) state_d = WAIT_VS;
      WAIT_VS: if (vs_fall) state_d = ACTIVE;
      ACTIVE: begin
        if (vsync)         state_d = WAIT_VS;
        else if (last_pix) state_d = DONE;
      end
      DONE:    state_d = cont ? WAIT_VS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_active   = (state_q == ACTIVE) && !vsync;
    start_frame = (state_q == WAIT_VS) && vs_fall;
  end

  // A source pixel completes on its second byte; it is taken only inside the active window
  assign pix_done  = in_active && href && phase_q;
  assign pix_taken = pix_done && (col_q < COL_END) && (row_q < ROW_END);
  assign pix_keep  = pix_taken && ((col_q & COL_MASK) == '0) && ((row_q & ROW_MASK) == '0);
  assign last_pix  = pix_taken && (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_comb begin
    phase_d   = phase_q;
    byte1_d   = byte1_q;
    col_d     = col_q;
    row_d     = row_q;
    ptr_d     = ptr_q;
    wr_addr_d = wr_addr_q;
    rgb_d     = rgb_q;
    wr_en_d   = 1'b0;
    done_d    = last_pix;
    err_d     = err_q;
    if (start_frame) begin
      phase_d = 1'b0;
      col_d   = '0;
      row_d   = '0;
      ptr_d   = '0;
      err_d   = 1'b0;
    end else if (in_active) begin
      if (href) begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          byte1_d = D;
        end else if (pix_taken) begin
          col_d = col_q + 1'b1;
          if (pix_keep) begin
            rgb_d     = rgb_pack;
            wr_addr_d = ptr_q;
            ptr_d     = ptr_q + 1'b1;
            wr_en_d   = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end else if (href_fall) begin
        // an odd trailing byte is simply forgotten by clearing the phase
        if ((col_q != COL_END) || phase_q) err_d = 1'b1;
        phase_d = 1'b0;
        col_d   = '0;
        if (row_q != ROW_END) row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      phase_q   <= 1'b0;
      byte1_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      ptr_q     <= '0;
      wr_addr_q <= '0;
      rgb_q     <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      vsync_q   <= vsync;
      href_q    <= href;
      phase_q   <= phase_d;
      byte1_q   <= byte1_d;
      col_q     <= col_d;
      row_q     <= row_d;
      ptr_q     <= ptr_d;
      wr_addr_q <= wr_addr_d;
      rgb_q     <= rgb_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign RGB        = rgb_q;
  assign wr_addr    = wr_addr_q;
  assign wr_en      = wr_en_q;
  assign frame_done = done_q;
  assign line_err   = err_q;

`ifdef FRAME_CAPTURE_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (done_q && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (err_d && !err_q && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640: source pixels per line (each pixel is two bytes).
REQ-002 Parameter V_ACTIVE, default 480: source lines per frame.
REQ-003 Parameter DECIM, default 2: power-of-two downscale factor in each axis; legal values 1, 2, 4.
REQ-004 Parameter ADDR_W, default 17: write-address width; shall satisfy 2**ADDR_W >= (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM).
REQ-005 pclk  input  1  sole clock; all logic on the rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 D  input  8  camera data byte.
REQ-008 vsync  input  1  frame blanking; high = between frames.
REQ-009 href  input  1  line-valid qualifier for D.
REQ-010 fmt  input  1  pixel format: 0 = RGB444 (xR GB), 1 = RGB565.
REQ-011 cont  input  1  1 = capture every frame; 0 = single-shot, gated by arm.
REQ-012 arm  input  1  single-cycle request to capture the next frame.
REQ-013 RGB  output  12  captured pixel, {R[3:0],G[3:0],B[3:0]}.
REQ-014 wr_addr  output  ADDR_W  frame-buffer write address.
REQ-015 wr_en  output  1  write strobe; one cycle per kept pixel.
REQ-016 frame_done  output  1  one-cycle pulse on the last write of a frame.
REQ-017 line_err  output  1  sticky flag for a malformed line.

Function
REQ-018 FSM states: IDLE, WAIT_VS, ACTIVE, DONE.
- IDLE to WAIT_VS when cont=1 or arm=1.
- WAIT_VS to ACTIVE on the first cycle with vsync=0 that follows a cycle with vsync=1.
- ACTIVE to DONE after the last source pixel is taken.
- DONE to WAIT_VS if cont=1, else to IDLE.
REQ-019 In ACTIVE, byte phase toggles on every href=1 cycle: phase 0 latches byte1, phase 1 latches byte2; back-to-back pixels shall be accepted with no dead cycles.
REQ-020 Pixel mapping:
- RGB444: RGB = {byte1[3:0], byte2[7:4], byte2[3:0]}.
- RGB565: RGB = {byte1[7:4], byte1[2:0], byte2[7], byte2[4:1]}.
REQ-021 Latency: RGB, wr_addr and wr_en are registered and valid one pclk after byte2 is sampled.
REQ-022 A pixel is kept only when (col mod DECIM)==0 and (row mod DECIM)==0.
REQ-023 The first kept pixel of a frame is written at address 0; each further kept pixel increments the address by 1.
REQ-024 col increments per completed pixel and clears on href falling; row increments on each href falling edge in ACTIVE.
REQ-025 Overlong line: pixels with col >= H_ACTIVE are dropped and line_err is set.
REQ-026 Excess lines: lines with row >= V_ACTIVE are dropped and line_err is set.
REQ-027 Short or odd line: line_err is set if href falls with col != H_ACTIVE or with byte phase 1.
REQ-028 A dangling byte left by an odd line is discarded.
REQ-029 frame_done is asserted in the same cycle as wr_en for source pixel (H_ACTIVE-1, V_ACTIVE-1) when that pixel is kept; otherwise it is asserted one cycle after that pixel completes.
REQ-030 vsync=1 while in ACTIVE aborts the frame: return to WAIT_VS, no frame_done, and the next frame restarts at address 0.
REQ-031 arm while ACTIVE or DONE is ignored; arm and cont together behave as cont.
REQ-032 line_err clears only on rst or on entry to ACTIVE.

Reset
REQ-033 While rst=1 at a clock edge:
- FSM goes to IDLE.
- RGB, wr_addr, wr_en, frame_done and line_err go to 0.
- col, row, byte phase and the address pointer go to 0.
REQ-034 rst mid-line shall produce no write in the following cycle.

Configuration
REQ-035 Macro FRAME_CAPTURE_STATS_EN, when defined, adds two outputs, each saturating and cleared by rst:
- frame_cnt (16 bits): increments on each frame_done.
- err_cnt (8 bits): increments on each line_err set event.
REQ-036 Without FRAME_CAPTURE_STATS_EN, these ports and their counters do not exist; all other behaviour is identical.

Structure
REQ-037 Package cam_pkg holds:
- the FSM state typedef;
- the pixel format enum (FMT_RGB444, FMT_RGB565);
- the localparam PIX_W=12.
REQ-038 One sub-module, pixel_pack: combinational conversion of byte1, byte2 and fmt to 12-bit RGB; frame_capture registers its output.

Verification
REQ-039 H_ACTIVE=8, V_ACTIVE=4, DECIM=1, cont=1, one clean frame -> 32 wr_en pulses at addresses 0..31, frame_done coincident with address 31, line_err=0.
REQ-040 fmt=1, bytes 0xF8,0x1F -> RGB=0xF0F; fmt=0, bytes 0x0A,0xBC -> RGB=0xABC; each valid one pclk after byte2.
REQ-041 DECIM=2 with the same 8x4 frame -> 8 writes at addresses 0..7, taken from even rows and even columns only.
REQ-042 Line 1 of a frame carries only 6 pixels -> line_err=1, and the writes are the pixels actually received, numbered contiguously.
REQ-043 vsync raised after 10 pixels -> no frame_done; the next frame writes from address 0.
REQ-044 cont=0 without arm -> no writes; one arm pulse -> exactly one frame captured, then IDLE; rst in mid-line -> all outputs 0 on the next cycle.
